// File: rtl/mem_port_arbiter.sv
// Round-robin access sequencer for the multi-cycle CPU's single-port RAM.
// Serves instruction fetch (into ir) and data loads/stores (into d_rdata), one access at a time.
module mem_port_arbiter #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] ir,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [31:0]       d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_dout,
    output logic              busy
);

    localparam int NREQ = 2;
    localparam logic ID_FETCH = 1'b0;
    localparam logic ID_DATA  = 1'b1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    state_t              state_reg;
    logic                id_reg;
    logic                last_id_reg;
    logic [ADDR_W-1:0]   addr_reg;
    logic [DATA_W-1:0]   wdata_reg;
    logic                we_reg;
    logic                ram_we_reg;
    logic                busy_reg;
    logic [NREQ-1:0]     ack_reg;
    logic [DATA_W-1:0]   ir_reg;
    logic [DATA_W-1:0]   rdata_reg;

    logic [NREQ-1:0]     req_vec;
    logic [NREQ-1:0]     elig;
    logic [31:0]         req_addr_full [NREQ];
    logic [ADDR_W-1:0]   req_addr_trunc [NREQ];
    logic                grant_valid;
    logic                grant_id_next;
    logic                unused_addr_bits;

    assign req_vec          = {d_req, if_req};
    assign req_addr_full[0] = if_addr;
    assign req_addr_full[1] = d_addr;
    assign unused_addr_bits = ^{if_addr[31:ADDR_W], d_addr[31:ADDR_W]};

    // A requester still holding req in its own ack cycle is masked so it
    // cannot be re-granted before it has seen the ack.
    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_req
            assign elig[gi]           = req_vec[gi] & ~ack_reg[gi];
            assign req_addr_trunc[gi] = req_addr_full[gi][ADDR_W-1:0];
        end
    endgenerate

    always_comb begin
        grant_valid   = |elig;
        grant_id_next = ID_FETCH;
        case (elig)
            2'b01:   grant_id_next = ID_FETCH;
            2'b10:   grant_id_next = ID_DATA;
            2'b11:   grant_id_next = ~last_id_reg;
            default: grant_id_next = ID_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            id_reg      <= ID_FETCH;
            last_id_reg <= ID_DATA;
            addr_reg    <= '0;
            wdata_reg   <= '0;
            we_reg      <= 1'b0;
            ram_we_reg  <= 1'b0;
            busy_reg    <= 1'b0;
            ack_reg     <= '0;
            ir_reg      <= '0;
            rdata_reg   <= '0;
        end else begin
            ack_reg    <= '0;
            ram_we_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (grant_valid) begin
                        id_reg      <= grant_id_next;
                        last_id_reg <= grant_id_next;
                        addr_reg    <= req_addr_trunc[grant_id_next];
                        we_reg      <= grant_id_next & d_we;
                        ram_we_reg  <= grant_id_next & d_we;
                        wdata_reg   <= grant_id_next ? d_wdata : '0;
                        busy_reg    <= 1'b1;
                        state_reg   <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (we_reg) begin
                        ack_reg[ID_DATA] <= 1'b1;
                        busy_reg         <= 1'b0;
                        state_reg        <= IDLE;
                    end else begin
                        state_reg <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (id_reg == ID_FETCH) begin
                        ir_reg <= ram_dout;
                    end else begin
                        rdata_reg <= ram_dout;
                    end
                    ack_reg[id_reg] <= 1'b1;
                    busy_reg        <= 1'b0;
                    state_reg       <= IDLE;
                end
                default: begin
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // ram_we_reg is only ever set for the single ACCESS cycle of a store.
    assign ram_addr = addr_reg;
    assign ram_din  = wdata_reg;
    assign ram_we   = ram_we_reg;
    assign busy     = busy_reg;
    assign if_ack   = ack_reg[ID_FETCH];
    assign d_ack    = ack_reg[ID_DATA];
    assign ir       = ir_reg;
    assign d_rdata  = rdata_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural single-port RAM (1-cycle read latency).
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ack;
    logic [31:0] ir;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic [8:0]  ram_addr;
    logic [31:0] ram_din;
    logic        ram_we;
    logic [31:0] ram_dout;
    logic        busy;

    logic [31:0] mem [0:511];

    int errors = 0;
    int checks = 0;

    mem_port_arbiter #(.ADDR_W(9), .DATA_W(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_ack   (if_ack),
        .ir       (ir),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_ack    (d_ack),
        .d_rdata  (d_rdata),
        .ram_addr (ram_addr),
        .ram_din  (ram_din),
        .ram_we   (ram_we),
        .ram_dout (ram_dout),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Read-before-write single-port RAM
    always @(posedge clk) begin
        ram_dout <= mem[ram_addr];
        if (ram_we) mem[ram_addr] = ram_din;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic pulse_reset;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++; if (if_ack !== 1'b0) begin errors++; $display("FAIL reset_if_ack got=%b exp=0", if_ack); end
        checks++; if (d_ack !== 1'b0) begin errors++; $display("FAIL reset_d_ack got=%b exp=0", d_ack); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL reset_ram_we got=%b exp=0", ram_we); end
        checks++; if (ir !== 32'h0) begin errors++; $display("FAIL reset_ir got=%h exp=0", ir); end
        checks++; if (d_rdata !== 32'h0) begin errors++; $display("FAIL reset_d_rdata got=%h exp=0", d_rdata); end
        checks++; if (ram_addr !== 9'h0) begin errors++; $display("FAIL reset_ram_addr got=%h exp=0", ram_addr); end
        checks++; if (ram_din !== 32'h0) begin errors++; $display("FAIL reset_ram_din got=%h exp=0", ram_din); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy got=%b exp=0", busy); end
        $display("reset released");
    endtask

    task automatic test_fetch;
        @(negedge clk);
        if_addr = 32'h4;
        if_req  = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            checks++; if (if_ack !== (k == 3)) begin errors++; $display("FAIL fetch_if_ack cyc=%0d got=%b exp=%b", k, if_ack, (k == 3)); end
            checks++; if (busy !== (k < 3)) begin errors++; $display("FAIL fetch_busy cyc=%0d got=%b exp=%b", k, busy, (k < 3)); end
            checks++; if (d_ack !== 1'b0) begin errors++; $display("FAIL fetch_d_ack cyc=%0d got=%b exp=0", k, d_ack); end
            checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL fetch_ram_we cyc=%0d got=%b exp=0", k, ram_we); end
            if (k == 1) begin
                checks++; if (ram_addr !== 9'h004) begin errors++; $display("FAIL fetch_ram_addr got=%h exp=004", ram_addr); end
            end
            if (k == 3) begin
                checks++; if (ir !== 32'h8C010000) begin errors++; $display("FAIL fetch_ir got=%h exp=8c010000", ir); end
                if_req = 1'b0;
                $display("fetch addr=%h ir=%h", if_addr, ir);
            end
        end
    endtask

    task automatic test_store_load;
        @(negedge clk);
        d_we = 1'b1; d_addr = 32'h10; d_wdata = 32'hDEADBEEF; d_req = 1'b1;
        for (int k = 1; k <= 2; k++) begin
            @(negedge clk);
            checks++; if (ram_we !== (k == 1)) begin errors++; $display("FAIL store_ram_we cyc=%0d got=%b exp=%b", k, ram_we, (k == 1)); end
            checks++; if (d_ack !== (k == 2)) begin errors++; $display("FAIL store_d_ack cyc=%0d got=%b exp=%b", k, d_ack, (k == 2)); end
            if (k == 1) begin
                checks++; if (ram_addr !== 9'h010) begin errors++; $display("FAIL store_ram_addr got=%h exp=010", ram_addr); end
                checks++; if (ram_din !== 32'hDEADBEEF) begin errors++; $display("FAIL store_ram_din got=%h exp=deadbeef", ram_din); end
            end
        end
        d_req = 1'b0;
        checks++; if (d_rdata !== 32'h0) begin errors++; $display("FAIL store_d_rdata got=%h exp=0", d_rdata); end
        $display("store addr=%h data=%h", d_addr, d_wdata);
        @(negedge clk);
        d_we = 1'b0; d_req = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            checks++; if (d_ack !== (k == 3)) begin errors++; $display("FAIL load_d_ack cyc=%0d got=%b exp=%b", k, d_ack, (k == 3)); end
            checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL load_ram_we cyc=%0d got=%b exp=0", k, ram_we); end
        end
        checks++; if (d_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL load_d_rdata got=%h exp=deadbeef", d_rdata); end
        checks++; if (ir !== 32'h8C010000) begin errors++; $display("FAIL load_ir_unchanged got=%h exp=8c010000", ir); end
        d_req = 1'b0;
        $display("load addr=%h d_rdata=%h", d_addr, d_rdata);
    endtask

    task automatic test_round_robin;
        int   n_ack;
        logic exp_data;
        pulse_reset();
        @(negedge clk);
        if_addr = 32'h20; d_addr = 32'h30; d_we = 1'b0;
        if_req = 1'b1; d_req = 1'b1;
        n_ack = 0; exp_data = 1'b0;
        for (int c = 1; c <= 24; c++) begin
            @(negedge clk);
            checks++; if ((if_ack & d_ack) !== 1'b0) begin errors++; $display("FAIL rr_dual_ack cyc=%0d if_ack=%b d_ack=%b", c, if_ack, d_ack); end
            if (if_ack || d_ack) begin
                n_ack++;
                checks++; if (d_ack !== exp_data) begin errors++; $display("FAIL rr_order ack#%0d got_data=%b exp_data=%b", n_ack, d_ack, exp_data); end
                checks++; if (c != 3 * n_ack) begin errors++; $display("FAIL rr_timing ack#%0d cyc=%0d exp=%0d", n_ack, c, 3 * n_ack); end
                if (if_ack) begin
                    checks++; if (ir !== 32'h11111111) begin errors++; $display("FAIL rr_ir got=%h exp=11111111", ir); end
                    $display("rr fetch ack cyc=%0d ir=%h", c, ir);
                end else begin
                    checks++; if (d_rdata !== 32'h22222222) begin errors++; $display("FAIL rr_d_rdata got=%h exp=22222222", d_rdata); end
                    $display("rr data ack cyc=%0d d_rdata=%h", c, d_rdata);
                end
                exp_data = ~exp_data;
            end
            if (c == 24) begin
                if_req = 1'b0; d_req = 1'b0;
            end else begin
                if_req = ~if_ack; d_req = ~d_ack;
            end
        end
        checks++; if (n_ack != 8) begin errors++; $display("FAIL rr_ack_count got=%0d exp=8", n_ack); end
        // Lone fetch so the last-grant flag points at fetch before the next tie.
        @(negedge clk);
        if_req = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            checks++; if (if_ack !== (k == 3)) begin errors++; $display("FAIL tie_prep_if_ack cyc=%0d got=%b exp=%b", k, if_ack, (k == 3)); end
        end
        if_req = 1'b0;
        @(negedge clk);
        if_req = 1'b1; d_req = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            checks++; if (d_ack !== (k == 3)) begin errors++; $display("FAIL tie_d_ack cyc=%0d got=%b exp=%b", k, d_ack, (k == 3)); end
            checks++; if (if_ack !== (k == 6)) begin errors++; $display("FAIL tie_if_ack cyc=%0d got=%b exp=%b", k, if_ack, (k == 6)); end
            if (k == 3) d_req = 1'b0;
            if (k == 6) if_req = 1'b0;
        end
        $display("tie after fetch granted data first");
    endtask

    task automatic test_held_req;
        @(negedge clk);
        d_addr = 32'h30; d_we = 1'b0; d_req = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            checks++; if (d_ack !== (k == 3)) begin errors++; $display("FAIL held_a_d_ack cyc=%0d got=%b exp=%b", k, d_ack, (k == 3)); end
            if (k == 4 || k == 5) begin
                checks++; if (busy !== 1'b0) begin errors++; $display("FAIL held_a_busy cyc=%0d got=%b exp=0", k, busy); end
            end
            if (k == 4) d_req = 1'b0;
        end
        $display("held req one cycle past ack: single access");
        @(negedge clk);
        d_req = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            checks++; if (d_ack !== (k == 3 || k == 7)) begin errors++; $display("FAIL held_b_d_ack cyc=%0d got=%b exp=%b", k, d_ack, (k == 3 || k == 7)); end
            if (k == 4) begin
                checks++; if (busy !== 1'b0) begin errors++; $display("FAIL held_b_busy_ack cyc=4 got=%b exp=0", busy); end
            end
            if (k == 5) begin
                checks++; if (busy !== 1'b1) begin errors++; $display("FAIL held_b_busy_regrant cyc=5 got=%b exp=1", busy); end
            end
            if (k == 7) d_req = 1'b0;
        end
        $display("held req two cycles past ack: second access");
    endtask

    task automatic test_reset_mid_capture;
        @(negedge clk);
        d_addr = 32'h40; d_we = 1'b0; d_req = 1'b1;
        for (int k = 1; k <= 3; k++) @(negedge clk);
        checks++; if (d_rdata !== 32'h12345678) begin errors++; $display("FAIL rstcap_preload got=%h exp=12345678", d_rdata); end
        d_req = 1'b0;
        @(negedge clk);
        d_addr = 32'h30; d_req = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rstcap_busy_before got=%b exp=1", busy); end
        rst_n = 1'b0;
        d_req = 1'b0;
        #1;
        checks++; if (d_rdata !== 32'h0) begin errors++; $display("FAIL rstcap_d_rdata got=%h exp=0", d_rdata); end
        checks++; if (d_ack !== 1'b0) begin errors++; $display("FAIL rstcap_d_ack got=%b exp=0", d_ack); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstcap_busy got=%b exp=0", busy); end
        checks++; if (ir !== 32'h0) begin errors++; $display("FAIL rstcap_ir got=%h exp=0", ir); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            checks++; if (d_ack !== 1'b0) begin errors++; $display("FAIL rstcap_no_ack cyc=%0d got=%b exp=0", k, d_ack); end
        end
        if_addr = 32'h4; if_req = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            checks++; if (if_ack !== (k == 3)) begin errors++; $display("FAIL rstcap_fetch_ack cyc=%0d got=%b exp=%b", k, if_ack, (k == 3)); end
        end
        checks++; if (ir !== 32'h8C010000) begin errors++; $display("FAIL rstcap_fetch_ir got=%h exp=8c010000", ir); end
        if_req = 1'b0;
        $display("reset in capture, then fetch ir=%h", ir);
    endtask

    task automatic test_addr_wrap;
        @(negedge clk);
        d_we = 1'b1; d_addr = 32'h204; d_wdata = 32'hA5A5A5A5; d_req = 1'b1;
        @(negedge clk);
        checks++; if (ram_addr !== 9'h004) begin errors++; $display("FAIL wrap_ram_addr got=%h exp=004", ram_addr); end
        checks++; if (ram_we !== 1'b1) begin errors++; $display("FAIL wrap_ram_we got=%b exp=1", ram_we); end
        @(negedge clk);
        checks++; if (d_ack !== 1'b1) begin errors++; $display("FAIL wrap_d_ack got=%b exp=1", d_ack); end
        d_req = 1'b0; d_we = 1'b0;
        $display("store addr=%h wrapped data=%h", d_addr, d_wdata);
        @(negedge clk);
        if_addr = 32'h4; if_req = 1'b1;
        for (int k = 1; k <= 3; k++) @(negedge clk);
        checks++; if (if_ack !== 1'b1) begin errors++; $display("FAIL wrap_if_ack got=%b exp=1", if_ack); end
        checks++; if (ir !== 32'hA5A5A5A5) begin errors++; $display("FAIL wrap_ir got=%h exp=a5a5a5a5", ir); end
        if_req = 1'b0;
        $display("fetch addr=%h ir=%h", if_addr, ir);
    endtask

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = 32'h0;
        mem[9'h004] = 32'h8C010000;
        mem[9'h020] = 32'h11111111;
        mem[9'h030] = 32'h22222222;
        mem[9'h040] = 32'h12345678;
        rst_n = 1'b0;
        if_req = 1'b0; if_addr = 32'h0;
        d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0;

        test_reset();
        test_fetch();
        test_store_load();
        test_round_robin();
        test_held_req();
        test_reset_mid_capture();
        test_addr_wrap();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
